ps2_kbd_ctrl: RTL and testbench

Wishbone-mapped PS/2 keyboard controller that replaces the free-running PS/2-clocked capture logic. It runs entirely in the system clock domain: it synchronises PS2_CLK and PS2_DATA, frames 11-bit packets, checks odd parity, and detects bit timeouts. It then sequences the scan-code prefixes (E0 = extended, F0 = break) into single key events and buffers them in a FIFO that the SweRV core drains over Wishbone, with an optional level interrupt.

---
 rtl/ps2_kbd_pkg.sv | 28 ++
 rtl/ps2_kbd_if.sv | 22 ++
 rtl/ps2_kbd_ctrl_fifo.sv | 51 +++++
 rtl/ps2_kbd_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard controller.
package ps2_kbd_pkg;

  // Word offsets decoded from wb_adr_i[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Scan-code prefixes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // One decoded key event as stored in the FIFO
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  // PS/2 frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

endpackage

// File: rtl/ps2_kbd_if.sv
// Wishbone slave bus bundle for the PS/2 keyboard controller.
interface ps2_kbd_if;
  logic        wb_cyc_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/ps2_kbd_ctrl_fifo.sv
// Synchronous event FIFO; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter.
module ps2_evt_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 10,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is read combinationally so the bus can register it with the ack
  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write (no reset needed)
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: synchroniser, frame receiver, prefix decoder,
// event FIFO and Wishbone register slave, all in the clk domain.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic      clk,
  input  logic      wb_rst_i,
  input  logic      PS2_CLK,
  input  logic      PS2_DATA,
  ps2_kbd_if.slave  wb,
  output logic      irq_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] GAP_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Synchroniser: lines idle high, so reset to 1 to avoid a false edge
  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q, fall;
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      {clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q} <= '1;
    end else begin
      clk_s1_q   <= PS2_CLK;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= PS2_DATA;
      dat_s2_q   <= dat_s1_q;
    end
  end
  assign fall = clk_prev_q & ~clk_s2_q;

  frame_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] gap_q, gap_d;
  logic          byte_ok, byte_bad;
  logic          en_q, en_d, irq_en_q, irq_en_d, clr;

  // Frame receiver next state: advances on falling edges, aborts on a long gap
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    gap_d     = fall ? '0 : ((gap_q == GAP_LAST) ? gap_q : gap_q + CW'(1));
    if (!en_q) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: if (!dat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
        ST_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = ST_STOP;
        end
        default: begin
          // Odd parity: data bits plus parity bit must hold an odd number of ones
          if (dat_s2_q && ((^shift_q) ^ parity_q)) byte_ok = 1'b1;
          else                                    byte_bad = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && gap_q == GAP_LAST) begin
      state_d = ST_IDLE;
    end
  end

  // Frame receiver registers
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      gap_q     <= gap_d;
    end
  end

  // Decoder: good byte is registered, then prefixes update ext/brk or an event is pushed
  logic       byte_vld_q, ext_q, brk_q, push;
  logic [7:0] byte_q;
  assign push = byte_vld_q && (byte_q != SC_EXT) && (byte_q != SC_BRK);
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      byte_vld_q <= byte_ok;
      byte_q     <= shift_q;
      if (byte_vld_q) begin
        if (byte_q == SC_EXT)      ext_q <= 1'b1;
        else if (byte_q == SC_BRK) brk_q <= 1'b1;
        else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
    end
  end

  kbd_evt_t    evt_in, evt_out;
  logic        full, empty, pop;
  logic [AW:0] count;
  logic [3:0]  occ;
  assign evt_in = '{ext: ext_q, brk: brk_q, code: byte_q};
  assign occ    = 4'(count);

  ps2_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk(clk), .srst_i(wb_rst_i), .push_i(push), .pop_i(pop), .din_i(evt_in),
    .dout_o(evt_out), .full_o(full), .empty_o(empty), .count_o(count)
  );

  // Wishbone slave: one response per request, blocked while a response is out
  logic        ack_q, ack_d, err_q, err_d, pop_pend_q, pop_pend_d, req;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  adr;
  logic        ovf_q, irq_q;
  logic [7:0]  err_cnt_q;
  assign req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
  assign adr = wb.wb_adr_i[3:2];
  assign pop = ack_q & pop_pend_q;

  // Bus decode: response, read data and CTRL updates
  always_comb begin
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = '0;
    pop_pend_d = 1'b0;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    clr        = 1'b0;
    if (req) begin
      if (adr == 2'd3) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (!wb.wb_we_i) begin
          case (adr)
            REG_DATA: if (!empty) begin
              dat_d      = {1'b1, 21'b0, evt_out};
              pop_pend_d = 1'b1;
            end
            REG_STATUS: dat_d = {12'b0, occ, err_cnt_q, 5'b0, ovf_q, full, empty};
            REG_CTRL:   dat_d = {30'b0, irq_en_q, en_q};
            default:    dat_d = '0;
          endcase
        end else if (adr == REG_CTRL) begin
          en_d     = wb.wb_dat_i[0];
          irq_en_d = wb.wb_dat_i[1];
          clr      = wb.wb_dat_i[2];
        end
      end
    end
  end

  // Bus, control and status registers
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      pop_pend_q <= 1'b0;
      en_q       <= 1'b1;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      err_cnt_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      pop_pend_q <= pop_pend_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_en_q & ~empty;
      if (clr)                            ovf_q <= 1'b0;
      else if (push && full && !pop)      ovf_q <= 1'b1;
      if (clr)                            err_cnt_q <= '0;
      else if (byte_bad && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = irq_q;

  logic unused_bits;
  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:3]};

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed vector table, hand-written corner
// sequences and randomized byte streams checked against a queue model.
module tb_ps2_kbd_ctrl;
  import ps2_kbd_pkg::*;

  localparam int TO    = 200;
  localparam int HALF  = 12;
  localparam int DEPTH = 8;

  logic clk = 1'b0, rst = 1'b1, ps2c = 1'b1, ps2d = 1'b1, irq;
  int   n_pass = 0, n_chk = 0;

  ps2_kbd_if bus();

  ps2_kbd_ctrl #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .wb_rst_i(rst), .PS2_CLK(ps2c), .PS2_DATA(ps2d), .wb(bus), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #700000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", name, act, exp);
  endtask

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = 4'hF;
  endtask

  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic ack, output logic err);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_dat_i = wdat;
    ack = 1'b0; err = 1'b0; rdat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o || bus.wb_err_o) begin
        ack = bus.wb_ack_o; err = bus.wb_err_o; rdat = bus.wb_dat_o;
        break;
      end
    end
    bus_idle();
    if (!ack && !err) begin
      n_chk++;
      $display("FAIL wb_response adr=%h: got none want ack or err", adr);
    end
    $display("wb %s adr=%h wdat=%08h rdat=%08h ack=%0b err=%0b",
             we ? "wr" : "rd", adr, wdat, rdat, ack, err);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d; logic a, e;
    wb_access(adr, 1'b0, 32'h0, d, a, e);
    check(name, d, exp);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] d; logic a, e;
    wb_access(adr, 1'b1, wdat, d, a, e);
  endtask

  // Send the first nbits of an 11-bit frame (start, 8 data LSB first, odd parity, stop)
  task automatic send_bits(input logic [7:0] b, input logic bad, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  // Full frame whose DATA read is timed so the pop lands on the same edge as the push:
  // two synchroniser flops, a history flop, STOP evaluation, then push one cycle later.
  task automatic send_pop_at_stop(input logic [7:0] b, output logic [31:0] rdat, output logic ack);
    logic [10:0] fr;
    fr = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ps2d = fr[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 32'h0;
    @(negedge clk);
    ack = bus.wb_ack_o; rdat = bus.wb_dat_o;
    bus_idle();
    $display("wb rd adr=00000000 rdat=%08h ack=%0b (timed with push)", rdat, ack);
    repeat (HALF - 2) @(negedge clk);
    ps2c = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Directed vectors: up to three bytes and the DATA word they must produce
  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          n;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[5];

  function automatic vec_t mkv(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, int n, logic [31:0] exp);
    vec_t v;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n; v.exp = exp;
    return v;
  endfunction

  // Reference model: prefixes modify the next key, everything else becomes an event
  logic [31:0] exp_q[$];
  logic        ext_m = 1'b0, brk_m = 1'b0;
  int          err_m = 0;

  task automatic model_byte(input logic [7:0] b, input logic bad);
    if (bad) begin
      if (err_m < 255) err_m++;
    end else if (b == 8'hE0) ext_m = 1'b1;
    else if (b == 8'hF0) brk_m = 1'b1;
    else begin
      exp_q.push_back(32'h8000_0000 + (32'(ext_m) << 9) + (32'(brk_m) << 8) + 32'(b));
      ext_m = 1'b0; brk_m = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        a, e;
    logic [7:0]  b;
    logic        bad;
    int          n, sz;

    bus_idle();
    vecs[0] = mkv(8'h1C, 8'h00, 8'h00, 1, 32'h8000001C);
    vecs[1] = mkv(8'hF0, 8'h1C, 8'h00, 2, 32'h8000011C);
    vecs[2] = mkv(8'hE0, 8'hF0, 8'h75, 3, 32'h80000375);
    vecs[3] = mkv(8'h1C, 8'h00, 8'h00, 1, 32'h8000001C);
    vecs[4] = mkv(8'hE0, 8'h6B, 8'h00, 2, 32'h8000026B);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dat", bus.wb_dat_o, 32'h0);
    check("rst_ack", 32'(bus.wb_ack_o), 32'h0);
    check("rst_err", 32'(bus.wb_err_o), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    rd_chk("rst_status", 32'h4, 32'h1);
    rd_chk("rst_ctrl", 32'h8, 32'h1);

    // Vector table: make, break, extended break, prefix clearing
    foreach (vecs[i]) begin
      send(vecs[i].b0);
      if (vecs[i].n > 1) send(vecs[i].b1);
      if (vecs[i].n > 2) send(vecs[i].b2);
      rd_chk($sformatf("vec%0d_data", i), 32'h0, vecs[i].exp);
      rd_chk($sformatf("vec%0d_status", i), 32'h4, 32'h1);
    end

    // Parity error counted and discarded, then cleared via CTRL
    send_bits(8'h1C, 1'b1, 11);
    rd_chk("par_status", 32'h4, 32'h101);
    rd_chk("par_data", 32'h0, 32'h0);
    wr(32'h8, 32'h5);
    rd_chk("clr_status", 32'h4, 32'h1);
    rd_chk("clr_ctrl", 32'h8, 32'h1);

    // Bit timeout aborts a partial frame without an error
    send_bits(8'h55, 1'b0, 5);
    repeat (TO + 20) @(negedge clk);
    rd_chk("to_status", 32'h4, 32'h1);
    send(8'h2A);
    rd_chk("to_data", 32'h0, 32'h8000002A);

    // Disabled receiver ignores traffic
    wr(32'h8, 32'h0);
    send(8'h1C);
    rd_chk("dis_status", 32'h4, 32'h1);
    wr(32'h8, 32'h1);

    // Overflow: nine codes, first eight kept in order
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    rd_chk("ovf_status", 32'h4, 32'h80006);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("ovf_rd%0d", i), 32'h0, 32'h80000010 + 32'(i));
    rd_chk("ovf_rd_empty", 32'h0, 32'h0);
    wr(32'h8, 32'h5);
    rd_chk("ovf_clr", 32'h4, 32'h1);

    // Push and pop on the same edge while full: no overflow, new event kept
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    rd_chk("pp_full", 32'h4, 32'h80002);
    send_pop_at_stop(8'h28, d, a);
    check("pp_ack", 32'(a), 32'h1);
    check("pp_data", d, 32'h80000020);
    rd_chk("pp_status", 32'h4, 32'h80002);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("pp_rd%0d", i), 32'h0, 32'h80000021 + 32'(i));
    rd_chk("pp_empty", 32'h4, 32'h1);

    // Randomized byte streams against the model
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 9))
          0, 1:    b = 8'hE0;
          2, 3:    b = 8'hF0;
          default: begin
            b = 8'($urandom_range(0, 255));
            while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom_range(0, 255));
          end
        endcase
        bad = ($urandom_range(0, 7) == 0);
        send_bits(b, bad, 11);
        model_byte(b, bad);
      end
      sz = exp_q.size();
      rd_chk($sformatf("rnd%0d_status", r), 32'h4,
             (32'(sz) << 16) + (32'(err_m) << 8) + (sz == DEPTH ? 32'h2 : 32'h0) + (sz == 0 ? 32'h1 : 32'h0));
      while (exp_q.size() > 0) rd_chk($sformatf("rnd%0d_data", r), 32'h0, exp_q.pop_front());
      rd_chk($sformatf("rnd%0d_empty", r), 32'h0, 32'h0);
    end
    if (ext_m || brk_m) begin
      send(8'h11);
      model_byte(8'h11, 1'b0);
      rd_chk("rnd_flush", 32'h0, exp_q.pop_front());
    end
    wr(32'h8, 32'h5);

    // Interrupt follows FIFO occupancy when enabled
    wr(32'h8, 32'h3);
    send(8'h1C);
    check("irq_rise", 32'(irq), 32'h1);
    rd_chk("irq_data", 32'h0, 32'h8000001C);
    repeat (2) @(negedge clk);
    check("irq_fall", 32'(irq), 32'h0);

    // Reserved offset: error termination, no ack, no effect
    wb_access(32'hC, 1'b0, 32'h0, d, a, e);
    check("rsv_rd_err", 32'(e), 32'h1);
    check("rsv_rd_ack", 32'(a), 32'h0);
    check("rsv_rd_dat", d, 32'h0);
    wb_access(32'hC, 1'b1, 32'h0, d, a, e);
    check("rsv_wr_err", 32'(e), 32'h1);
    rd_chk("rsv_ctrl", 32'h8, 32'h3);

    // Reset mid-frame with a bus request pending
    send_bits(8'h33, 1'b1, 11);
    send(8'h4B);
    check("pre_rst_irq", 32'(irq), 32'h1);
    send_bits(8'h12, 1'b0, 4);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", 32'(bus.wb_ack_o), 32'h0);
    check("mid_rst_err", 32'(bus.wb_err_o), 32'h0);
    check("mid_rst_dat", bus.wb_dat_o, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    bus_idle();
    rst = 1'b0;
    rd_chk("post_rst_status", 32'h4, 32'h1);
    rd_chk("post_rst_ctrl", 32'h8, 32'h1);
    send(8'h2A);
    rd_chk("post_rst_data", 32'h0, 32'h8000002A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
